// File: rtl/ysyx_040066_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encodings and
// iteration counts for full-width and word operations.
package ysyx_040066_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_ITER_D = 64;
  localparam int DIV_ITER_W = 32;
  localparam int DIV_CNT_W  = 7;

endpackage

// File: rtl/ysyx_040066_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module ysyx_040066_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] dsr_mag,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   w_partial;
  logic [XLEN-1:0] w_diff_lo;
  logic            w_ge;

  assign w_partial = {rem_in, dvd_bit};
  assign w_ge      = (w_partial >= {1'b0, dsr_mag});
  // The true difference is below the divisor whenever it is kept, so the
  // modular low half is exact.
  assign w_diff_lo = w_partial[XLEN-1:0] - dsr_mag;

  assign q_bit   = w_ge;
  assign rem_out = w_ge ? w_diff_lo : w_partial[XLEN-1:0];

endmodule

// File: rtl/ysyx_040066_divider.sv
// RV64M divider (DIV/DIVU/REM/REMU and W forms): one quotient bit per cycle,
// quotient and remainder returned together through a valid/ready handshake.
module ysyx_040066_divider
  import ysyx_040066_divider_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic [1:0]      dbg_state
);

  localparam int HALF = XLEN / 2;

  // Handshake: a request is taken on an edge where in_valid & in_ready & !flush;
  // a result leaves on an edge where out_valid & out_ready. in_ready is high only
  // in IDLE, out_valid only in DONE, and flush overrides both transfers.

  div_state_e             r_state, w_next;
  logic [DIV_CNT_W-1:0]   r_cnt;
  logic [XLEN-1:0]        r_rem, r_dvd, r_dsr, r_quot, r_remd;
  logic                   r_sign_q, r_sign_r, r_word;

  logic [XLEN-1:0]        w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_zero_rem;
  logic [XLEN-1:0]        w_step_rem, w_q_neg, w_r_neg, w_q_fin, w_r_fin;
  logic                   w_sa, w_sb, w_b_zero, w_accept, w_step_q;

  always_comb begin
    w_a_ext = dividend;
    w_b_ext = divisor;
    if (div_word) begin
      w_a_ext = {{HALF{div_signed & dividend[HALF-1]}}, dividend[HALF-1:0]};
      w_b_ext = {{HALF{div_signed & divisor[HALF-1]}}, divisor[HALF-1:0]};
    end
  end

  assign w_sa       = div_signed & w_a_ext[XLEN-1];
  assign w_sb       = div_signed & w_b_ext[XLEN-1];
  assign w_a_abs    = w_sa ? -w_a_ext : w_a_ext;
  assign w_b_abs    = w_sb ? -w_b_ext : w_b_ext;
  assign w_b_zero   = (w_b_ext == '0);
  // Division by zero returns the dividend; word forms always sign-extend it.
  assign w_zero_rem = div_word ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]} : dividend;
  assign w_accept   = (r_state == IDLE) & in_valid & ~flush;

  ysyx_040066_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (r_rem),
    .dvd_bit (r_dvd[XLEN-1]),
    .dsr_mag (r_dsr),
    .rem_out (w_step_rem),
    .q_bit   (w_step_q)
  );

  assign w_q_neg = r_sign_q ? -r_dvd : r_dvd;
  assign w_r_neg = r_sign_r ? -r_rem : r_rem;
  assign w_q_fin = r_word ? {{HALF{w_q_neg[HALF-1]}}, w_q_neg[HALF-1:0]} : w_q_neg;
  assign w_r_fin = r_word ? {{HALF{w_r_neg[HALF-1]}}, w_r_neg[HALF-1:0]} : w_r_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (in_valid) w_next = w_b_zero ? DONE : CALC;
        CALC: if (r_cnt == DIV_CNT_W'(1)) w_next = FIX;
        FIX:  w_next = DONE;
        DONE: if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_quot   <= '0;
      r_remd   <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_word   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= div_word ? DIV_CNT_W'(DIV_ITER_W) : DIV_CNT_W'(DIV_ITER_D);
      r_rem    <= '0;
      // Word magnitudes are pre-aligned to the top so the shifter always
      // consumes from bit XLEN-1 and quotient bits fill from the bottom.
      r_dvd    <= div_word ? {w_a_abs[HALF-1:0], {HALF{1'b0}}} : w_a_abs;
      r_dsr    <= w_b_abs;
      r_sign_q <= w_sa ^ w_sb;
      r_sign_r <= w_sa;
      r_word   <= div_word;
      if (w_b_zero) begin
        r_quot <= '1;
        r_remd <= w_zero_rem;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_step_rem;
      r_dvd <= {r_dvd[XLEN-2:0], w_step_q};
      r_cnt <= r_cnt - DIV_CNT_W'(1);
    end else if (r_state == FIX && !flush) begin
      r_quot <= w_q_fin;
      r_remd <= w_r_fin;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quot;
  assign remainder = r_remd;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ysyx_040066_divider.sv
// Self-checking bench for ysyx_040066_divider: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_ysyx_040066_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        div_signed = 1'b0;
  logic        div_word = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  ysyx_040066_divider #(.XLEN(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_signed (div_signed),
    .div_word   (div_word),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics, computed with plain arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input logic sgn, input logic word,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output int lat);
    logic [31:0] a32, b32, q32, r32;
    int          sa32, sb32;
    longint      sa, sb;
    a32 = a[31:0];
    b32 = b[31:0];
    if (word) begin
      lat = 34;
      if (b32 == 32'd0) begin
        q = '1;
        r = {{32{a32[31]}}, a32};
        lat = 1;
        return;
      end
      if (sgn) begin
        sa32 = a32;
        sb32 = b32;
        if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
          q32 = a32;
          r32 = 32'd0;
        end else begin
          q32 = sa32 / sb32;
          r32 = sa32 % sb32;
        end
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      lat = 66;
      if (b == 64'd0) begin
        q = '1;
        r = a;
        lat = 1;
        return;
      end
      if (sgn) begin
        sa = a;
        sb = b;
        if (a == 64'h8000_0000_0000_0000 && b == '1) begin
          q = a;
          r = '0;
        end else begin
          q = sa / sb;
          r = sa % sb;
        end
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  // driver: issue one op, check latency, optional backpressure, results
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sgn, input logic word, input int hold);
    logic [63:0] eq, er, got_q, got_r;
    int          elat, lat;
    ref_div(a, b, sgn, word, eq, er, elat);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    wait_idle();
    @(negedge clk);
    dividend   = a;
    divisor    = b;
    div_signed = sgn;
    div_word   = word;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    div_signed = 1'($urandom_range(0, 1));
    div_word   = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    got_q = exp_q.pop_front();
    got_r = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_hold_q"}, quotient, got_q);
    end
    check({tag, "_q"}, quotient, got_q);
    check({tag, "_r"}, remainder, got_r);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin : main
    logic [63:0] a, b;
    logic        seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_quot", quotient, 64'd0);
    check("rst_rem", remainder, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;

    run_op("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 0);
    check("divu_100_7_direct", quotient, 64'd14);
    run_op("div_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 0);
    check("div_m7_2_direct", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_5_0", 64'd5, 64'd0, 1'b1, 1'b0, 0);
    run_op("divuw_zero", 64'h0000_0000_8000_0000, 64'd0, 1'b0, 1'b1, 0);
    check("divuw_zero_direct", remainder, 64'hFFFF_FFFF_8000_0000);
    run_op("div_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 0);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 0);
    check("divw_ovf_direct", quotient, 64'hFFFF_FFFF_8000_0000);
    run_op("divuw_max_1", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 0);
    run_op("remw_neg", 64'h1234_5678_FFFF_FFF9, 64'h0000_0000_0000_0002, 1'b1, 1'b1, 0);
    run_op("backpressure", 64'd1000, 64'd33, 1'b0, 1'b0, 5);

    // flush mid-CALC
    wait_idle();
    @(negedge clk);
    dividend = 64'hDEAD_BEEF_0000_1234;
    divisor  = 64'd3;
    div_signed = 1'b0;
    div_word = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {63'd0, seen}, 64'd0);
    run_op("remu_17_5", 64'd17, 64'd5, 1'b0, 1'b0, 0);
    check("remu_17_5_direct", remainder, 64'd2);

    // reset in the middle of an operation
    wait_idle();
    @(negedge clk);
    dividend = 64'd999;
    divisor  = 64'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_quot", quotient, 64'd0);
    check("midrst_rem", remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = {$urandom, $urandom};
        1: b = 64'($urandom_range(1, 20));
        2: b = '0;
        3: b = '1;
        4: b = {32'd0, $urandom};
        default: b = -64'($urandom_range(1, 1000));
      endcase
      if ($urandom_range(0, 7) == 0) a = 64'h8000_0000_0000_0000;
      run_op("rand", a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
